demux_pingpong_ctrl: RTL and testbench

- Controller that steers a 10-bit pixel/feature stream into two alternating destination banks (ping-pong) through a demux_1_to_2_10bits instance.
- Counts accepted beats, switches bank after BLOCK_LEN beats, and stalls upstream while the next bank is still held by its consumer.
- Sits between a conv/pool layer output and two line/feature-map buffers in the LeNet5 pipeline.

---
 rtl/lenet_pkg.sv | 28 ++
 rtl/demux_pingpong_ctrl_if.sv | 31 +++
 rtl/demux_pingpong_ctrl_demux.sv | 14 +
 rtl/demux_pingpong_ctrl.sv | 132 +++++++++++++
 tb/tb_demux_pingpong_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet5 pipeline definitions: pixel width, row length and the
// ping-pong controller state encoding.
package lenet_pkg;

  localparam int PIX_W   = 10;
  localparam int ROW_LEN = 28;

  typedef enum logic [1:0] {
    FILL_1 = 2'd0,
    FILL_2 = 2'd1,
    WAIT_1 = 2'd2,
    WAIT_2 = 2'd3
  } pp_state_e;

  // Bank 2 is selected while filling it or while waiting for it to free up.
  function automatic logic sel_of(input pp_state_e s);
    logic r;
    case (s)
      FILL_1:  r = 1'b0;
      WAIT_1:  r = 1'b0;
      FILL_2:  r = 1'b1;
      WAIT_2:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demux_pingpong_ctrl_if.sv
// Stream, bank and release signals of the ping-pong controller.
// The slave modport is the controller; the master modport is its environment.
interface demux_pingpong_ctrl_if;

  logic [lenet_pkg::PIX_W-1:0] din;
  logic                        din_valid;
  logic                        din_ready;
  logic [lenet_pkg::PIX_W-1:0] dout_1;
  logic [lenet_pkg::PIX_W-1:0] dout_2;
  logic                        dout_valid_1;
  logic                        dout_valid_2;
  logic                        release_1;
  logic                        release_2;
  logic                        bank_full_1;
  logic                        bank_full_2;
  logic                        block_done;
  logic                        sel;

  modport slave (
    input  din, din_valid, release_1, release_2,
    output din_ready, dout_1, dout_2, dout_valid_1, dout_valid_2,
           bank_full_1, bank_full_2, block_done, sel
  );

  modport master (
    output din, din_valid, release_1, release_2,
    input  din_ready, dout_1, dout_2, dout_valid_1, dout_valid_2,
           bank_full_1, bank_full_2, block_done, sel
  );

endinterface

// File: rtl/demux_pingpong_ctrl_demux.sv
// 1-to-2 demultiplexer for 10-bit pixels; the unselected output is driven to zero.
module demux_1_to_2_10bits
  import lenet_pkg::*;
(
  input  logic [PIX_W-1:0] din,
  input  logic             sel,
  output logic [PIX_W-1:0] dout_1,
  output logic [PIX_W-1:0] dout_2
);

  assign dout_1 = sel ? {PIX_W{1'b0}} : din;
  assign dout_2 = sel ? din : {PIX_W{1'b0}};

endmodule

// File: rtl/demux_pingpong_ctrl.sv
// Ping-pong bank controller: counts accepted beats, alternates banks every
// BLOCK_LEN beats and stalls upstream while the next bank is still in use.
module demux_pingpong_ctrl
  import lenet_pkg::*;
#(
  parameter int DATA_W    = PIX_W,
  parameter int BLOCK_LEN = ROW_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  demux_pingpong_ctrl_if.slave  bus
);

  localparam int              CNT_W    = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  pp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bank_full_1_q, bank_full_1_d;
  logic             bank_full_2_q, bank_full_2_d;
  logic             sel_q, sel_d;
  logic             block_done_q, block_done_d;

  logic [DATA_W-1:0] din_s;
  logic              din_ready_s;
  logic              accept_s;
  logic              last_s;
  logic              full_1_kept_s;
  logic              full_2_kept_s;

  assign din_s         = bus.din;
  assign din_ready_s   = (state_q == FILL_1) || (state_q == FILL_2);
  assign accept_s      = bus.din_valid & din_ready_s;
  assign last_s        = accept_s & (cnt_q == CNT_LAST);
  // Full flags after this cycle's release; a release of an empty bank is a no-op.
  assign full_1_kept_s = bank_full_1_q & ~bus.release_1;
  assign full_2_kept_s = bank_full_2_q & ~bus.release_2;

  // Next-state, counter and full-flag logic; restart overrides everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_full_1_d = full_1_kept_s;
    bank_full_2_d = full_2_kept_s;
    block_done_d  = last_s;
    if (restart) begin
      state_d       = FILL_1;
      cnt_d         = {CNT_W{1'b0}};
      bank_full_1_d = 1'b0;
      bank_full_2_d = 1'b0;
      block_done_d  = 1'b0;
    end else begin
      if (last_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (accept_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        FILL_1: begin
          if (last_s) begin
            bank_full_1_d = 1'b1;
            state_d       = full_2_kept_s ? WAIT_2 : FILL_2;
          end else begin
            state_d = FILL_1;
          end
        end
        FILL_2: begin
          if (last_s) begin
            bank_full_2_d = 1'b1;
            state_d       = full_1_kept_s ? WAIT_1 : FILL_1;
          end else begin
            state_d = FILL_2;
          end
        end
        WAIT_1: begin
          if (!full_1_kept_s) begin
            state_d = FILL_1;
          end else begin
            state_d = WAIT_1;
          end
        end
        WAIT_2: begin
          if (!full_2_kept_s) begin
            state_d = FILL_2;
          end else begin
            state_d = WAIT_2;
          end
        end
        default: state_d = FILL_1;
      endcase
    end
    sel_d = sel_of(state_d);
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL_1;
      cnt_q         <= {CNT_W{1'b0}};
      bank_full_1_q <= 1'b0;
      bank_full_2_q <= 1'b0;
      sel_q         <= 1'b0;
      block_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_full_1_q <= bank_full_1_d;
      bank_full_2_q <= bank_full_2_d;
      sel_q         <= sel_d;
      block_done_q  <= block_done_d;
    end
  end

  assign bus.din_ready    = din_ready_s;
  assign bus.dout_valid_1 = accept_s & (state_q == FILL_1);
  assign bus.dout_valid_2 = accept_s & (state_q == FILL_2);
  assign bus.bank_full_1  = bank_full_1_q;
  assign bus.bank_full_2  = bank_full_2_q;
  assign bus.block_done   = block_done_q;
  assign bus.sel          = sel_q;

  demux_1_to_2_10bits u_demux (
    .din    (din_s),
    .sel    (sel_q),
    .dout_1 (bus.dout_1),
    .dout_2 (bus.dout_2)
  );

endmodule

// File: tb/tb_demux_pingpong_ctrl.sv
// Directed self-checking bench for demux_pingpong_ctrl with 28-beat blocks.
module tb_demux_pingpong_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  int   errors = 0;
  int   checks = 0;

  demux_pingpong_ctrl_if bus_if ();

  demux_pingpong_ctrl #(.DATA_W(10), .BLOCK_LEN(28)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [9:0] d, input logic v, input logic r1, input logic r2);
    @(negedge clk);
    bus_if.din       = d;
    bus_if.din_valid = v;
    bus_if.release_1 = r1;
    bus_if.release_2 = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.din = 10'd0; bus_if.din_valid = 1'b0;
    bus_if.release_1 = 1'b0; bus_if.release_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_if.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", bus_if.din_ready); end
    checks++; if (bus_if.sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%0b want=0", bus_if.sel); end
    checks++; if ({bus_if.bank_full_1, bus_if.bank_full_2} !== 2'b00) begin errors++; $display("FAIL reset_full got=%b want=00", {bus_if.bank_full_1, bus_if.bank_full_2}); end
    checks++; if (bus_if.block_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", bus_if.block_done); end
    checks++; if ({bus_if.dout_valid_1, bus_if.dout_valid_2} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b want=00", {bus_if.dout_valid_1, bus_if.dout_valid_2}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_bank1();
    for (int i = 1; i <= 28; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_if.dout_valid_1 !== 1'b1 || bus_if.dout_1 !== 10'(i) || bus_if.dout_valid_2 !== 1'b0 ||
          bus_if.dout_2 !== 10'd0 || bus_if.din_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill1_beat%0d got v1=%0b d1=%0h v2=%0b d2=%0h rdy=%0b want v1=1 d1=%0h v2=0 d2=0 rdy=1",
                 i, bus_if.dout_valid_1, bus_if.dout_1, bus_if.dout_valid_2, bus_if.dout_2, bus_if.din_ready, i);
      end
      tick();
      checks++; if (bus_if.block_done !== (i == 28)) begin errors++; $display("FAIL fill1_done%0d got=%0b want=%0b", i, bus_if.block_done, (i == 28)); end
    end
    checks++; if (bus_if.bank_full_1 !== 1'b1) begin errors++; $display("FAIL fill1_full got=%0b want=1", bus_if.bank_full_1); end
    checks++; if (bus_if.sel !== 1'b1) begin errors++; $display("FAIL fill1_sel got=%0b want=1", bus_if.sel); end
    checks++; if (bus_if.din_ready !== 1'b1) begin errors++; $display("FAIL fill1_ready got=%0b want=1", bus_if.din_ready); end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.block_done !== 1'b0) begin errors++; $display("FAIL fill1_done_pulse got=%0b want=0", bus_if.block_done); end
  endtask

  task automatic test_back_to_back_wait();
    for (int i = 1; i <= 28; i++) begin
      drive(10'(i + 256), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_if.dout_valid_2 !== 1'b1 || bus_if.dout_2 !== 10'(i + 256) || bus_if.dout_valid_1 !== 1'b0 || bus_if.dout_1 !== 10'd0) begin
        errors++;
        $display("FAIL fill2_beat%0d got v2=%0b d2=%0h v1=%0b d1=%0h want v2=1 d2=%0h v1=0 d1=0",
                 i, bus_if.dout_valid_2, bus_if.dout_2, bus_if.dout_valid_1, bus_if.dout_1, i + 256);
      end
      tick();
      checks++; if (bus_if.block_done !== (i == 28)) begin errors++; $display("FAIL fill2_done%0d got=%0b want=%0b", i, bus_if.block_done, (i == 28)); end
    end
    checks++; if (bus_if.sel !== 1'b0) begin errors++; $display("FAIL wait1_sel got=%0b want=0", bus_if.sel); end
    checks++; if (bus_if.din_ready !== 1'b0) begin errors++; $display("FAIL wait1_ready got=%0b want=0", bus_if.din_ready); end
    checks++; if ({bus_if.bank_full_1, bus_if.bank_full_2} !== 2'b11) begin errors++; $display("FAIL wait1_full got=%b want=11", {bus_if.bank_full_1, bus_if.bank_full_2}); end
    for (int i = 0; i < 3; i++) begin
      drive(10'h3FF, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({bus_if.din_ready, bus_if.dout_valid_1, bus_if.dout_valid_2} !== 3'b000) begin
        errors++; $display("FAIL wait1_ignore%0d got rdy/v1/v2=%b want=000", i, {bus_if.din_ready, bus_if.dout_valid_1, bus_if.dout_valid_2});
      end
      tick();
    end
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus_if.din_ready !== 1'b0) begin errors++; $display("FAIL rel1_ready_early got=%0b want=0", bus_if.din_ready); end
    tick();
    checks++; if (bus_if.din_ready !== 1'b1) begin errors++; $display("FAIL rel1_ready got=%0b want=1", bus_if.din_ready); end
    checks++; if (bus_if.sel !== 1'b0) begin errors++; $display("FAIL rel1_sel got=%0b want=0", bus_if.sel); end
    checks++; if ({bus_if.bank_full_1, bus_if.bank_full_2} !== 2'b01) begin errors++; $display("FAIL rel1_full got=%b want=01", {bus_if.bank_full_1, bus_if.bank_full_2}); end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simul_release();
    for (int i = 1; i <= 27; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(10'd28, 1'b1, 1'b0, 1'b1);
    checks++; if (bus_if.dout_valid_1 !== 1'b1 || bus_if.dout_1 !== 10'd28) begin errors++; $display("FAIL simul_last got v1=%0b d1=%0h want v1=1 d1=1c", bus_if.dout_valid_1, bus_if.dout_1); end
    tick();
    checks++; if (bus_if.sel !== 1'b1 || bus_if.din_ready !== 1'b1) begin errors++; $display("FAIL simul_state got sel=%0b rdy=%0b want sel=1 rdy=1", bus_if.sel, bus_if.din_ready); end
    checks++; if ({bus_if.bank_full_1, bus_if.bank_full_2} !== 2'b10) begin errors++; $display("FAIL simul_full got=%b want=10", {bus_if.bank_full_1, bus_if.bank_full_2}); end
    checks++; if (bus_if.block_done !== 1'b1) begin errors++; $display("FAIL simul_done got=%0b want=1", bus_if.block_done); end
    drive(10'h055, 1'b1, 1'b0, 1'b0);
    checks++; if (bus_if.dout_valid_2 !== 1'b1 || bus_if.dout_2 !== 10'h055) begin errors++; $display("FAIL simul_nostall got v2=%0b d2=%0h want v2=1 d2=55", bus_if.dout_valid_2, bus_if.dout_2); end
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_mid();
    for (int i = 1; i <= 9; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    do_restart();
    checks++; if (bus_if.sel !== 1'b0 || bus_if.din_ready !== 1'b1) begin errors++; $display("FAIL restart_state got sel=%0b rdy=%0b want sel=0 rdy=1", bus_if.sel, bus_if.din_ready); end
    checks++; if ({bus_if.bank_full_1, bus_if.bank_full_2, bus_if.block_done} !== 3'b000) begin errors++; $display("FAIL restart_flags got=%b want=000", {bus_if.bank_full_1, bus_if.bank_full_2, bus_if.block_done}); end
    for (int i = 1; i <= 28; i++) begin
      drive(10'(i + 512), 1'b1, 1'b0, 1'b0);
      checks++; if (bus_if.dout_valid_1 !== 1'b1 || bus_if.dout_1 !== 10'(i + 512)) begin errors++; $display("FAIL restart_beat%0d got v1=%0b d1=%0h want v1=1 d1=%0h", i, bus_if.dout_valid_1, bus_if.dout_1, i + 512); end
      tick();
      checks++; if (bus_if.block_done !== (i == 28)) begin errors++; $display("FAIL restart_done%0d got=%0b want=%0b", i, bus_if.block_done, (i == 28)); end
    end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.sel !== 1'b0 || {bus_if.bank_full_1, bus_if.bank_full_2} !== 2'b00) begin errors++; $display("FAIL areset_now got sel=%0b full=%b want sel=0 full=00", bus_if.sel, {bus_if.bank_full_1, bus_if.bank_full_2}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      drive(10'(i + 768), 1'b1, 1'b0, 1'b0);
      checks++; if (bus_if.dout_valid_1 !== 1'b1 || bus_if.dout_1 !== 10'(i + 768)) begin errors++; $display("FAIL areset_beat%0d got v1=%0b d1=%0h want v1=1 d1=%0h", i, bus_if.dout_valid_1, bus_if.dout_1, i + 768); end
      tick();
      checks++; if (bus_if.block_done !== (i == 28)) begin errors++; $display("FAIL areset_done%0d got=%0b want=%0b", i, bus_if.block_done, (i == 28)); end
    end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_valid();
    int beats = 0;
    int dones = 0;
    do_restart();
    for (int c = 0; c < 56; c++) begin
      logic v;
      v = (c % 2 == 0);
      drive(10'(c), v, 1'b0, 1'b0);
      if (bus_if.dout_valid_1 === 1'b1) beats++;
      checks++; if (bus_if.dout_valid_1 !== v || bus_if.dout_valid_2 !== 1'b0) begin errors++; $display("FAIL toggle_valid%0d got v1=%0b v2=%0b want v1=%0b v2=0", c, bus_if.dout_valid_1, bus_if.dout_valid_2, v); end
      tick();
      if (bus_if.block_done === 1'b1) dones++;
    end
    checks++; if (beats !== 28) begin errors++; $display("FAIL toggle_beats got=%0d want=28", beats); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL toggle_dones got=%0d want=1", dones); end
    checks++; if (bus_if.bank_full_1 !== 1'b1 || bus_if.sel !== 1'b1) begin errors++; $display("FAIL toggle_end got full1=%0b sel=%0b want 1 1", bus_if.bank_full_1, bus_if.sel); end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_spurious_release();
    do_restart();
    for (int i = 1; i <= 5; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(10'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus_if.din_ready !== 1'b1 || bus_if.dout_valid_1 !== 1'b0) begin errors++; $display("FAIL spur_comb got rdy=%0b v1=%0b want 1 0", bus_if.din_ready, bus_if.dout_valid_1); end
    tick();
    checks++;
    if ({bus_if.sel, bus_if.bank_full_1, bus_if.bank_full_2, bus_if.block_done, bus_if.din_ready} !== 5'b00001) begin
      errors++; $display("FAIL spur_regs got sel/f1/f2/done/rdy=%b want=00001", {bus_if.sel, bus_if.bank_full_1, bus_if.bank_full_2, bus_if.block_done, bus_if.din_ready});
    end
    for (int i = 6; i <= 27; i++) begin
      drive(10'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(10'd28, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (bus_if.bank_full_1 !== 1'b1 || bus_if.block_done !== 1'b1 || bus_if.sel !== 1'b1) begin errors++; $display("FAIL spur_last got full1=%0b done=%0b sel=%0b want 1 1 1", bus_if.bank_full_1, bus_if.block_done, bus_if.sel); end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_bank1();
    test_back_to_back_wait();
    test_simul_release();
    test_restart_mid();
    test_async_reset();
    test_toggle_valid();
    test_spurious_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
